// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_pkg
// Description : Shared types and default sizing for the SAR conversion
//               controller: FSM state encoding and resolution defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

   // Default DAC/result resolution in bits
   localparam int c_size = 8;

   // Default width of the sample-time count input
   localparam int c_scw = 8;

   // Conversion sequencer states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SAMPLE = 3'd1,
      SET    = 3'd2,
      CHK    = 3'd3,
      DONE   = 3'd4
   } sar_state_t;

endpackage : sar_pkg
`default_nettype wire

// File: rtl/sar_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sar_ctrl_if
// Description : Control/analog bundle for the SAR controller. The master
//               side is the upstream control logic plus the analog core
//               (comparator); the slave side is the conversion controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface sar_ctrl_if #(
   parameter int SIZE = sar_pkg::c_size,
   parameter int SCW  = sar_pkg::c_scw
) ();

   // Upstream control and comparator feedback
   logic            en_i;
   logic            soc_i;
   logic [SCW-1:0]  sample_cyc_i;
   logic            cmp_i;

   // Controller outputs to the analog core and register/IRQ logic
   logic            sample_n_o;
   logic [SIZE-1:0] dac_o;
   logic            busy_o;
   logic            eoc_o;
   logic [SIZE-1:0] result_o;

   modport master (
      output en_i,
      output soc_i,
      output sample_cyc_i,
      output cmp_i,
      input  sample_n_o,
      input  dac_o,
      input  busy_o,
      input  eoc_o,
      input  result_o
   );

   modport slave (
      input  en_i,
      input  soc_i,
      input  sample_cyc_i,
      input  cmp_i,
      output sample_n_o,
      output dac_o,
      output busy_o,
      output eoc_o,
      output result_o
   );

endinterface : sar_ctrl_if
`default_nettype wire

// File: rtl/sar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_ctrl
// Description : Successive-approximation conversion controller. On a start
//               request it runs a sample/hold window, then a binary search
//               of the DAC code against the comparator, latches the final
//               code and pulses end-of-conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_ctrl
   import sar_pkg::*;
#(
   parameter int SIZE = c_size,
   parameter int SCW  = c_scw
) (
   input  wire logic    wb_clk_i,
   input  wire logic    wb_rst_i,
   sar_ctrl_if.slave    bus
);

   // Bit-index width; at least one bit even for a degenerate 1-bit converter
   localparam int c_idx_w = (SIZE > 1) ? $clog2(SIZE) : 1;

   // First trial code: only the MSB set
   localparam logic [SIZE-1:0]    c_msb      = {1'b1, {(SIZE-1){1'b0}}};
   localparam logic [c_idx_w-1:0] c_idx_top  = c_idx_w'(SIZE - 1);
   localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
   localparam logic [SCW-1:0]     c_cnt_one  = SCW'(1);

   sar_state_t          r_state;
   logic [SCW-1:0]      r_cnt;
   logic [c_idx_w-1:0]  r_idx;
   logic [SIZE-1:0]     r_dac;
   logic [SIZE-1:0]     r_result;
   logic                r_sample_n;
   logic                r_busy;
   logic                r_eoc;

   logic [SCW-1:0]      w_s_len;
   logic [c_idx_w-1:0]  w_idx_dn;
   logic [SIZE-1:0]     w_kept;
   logic [SIZE-1:0]     w_trial;

   // A zero sample time still gives one tracking cycle
   assign w_s_len  = (bus.sample_cyc_i == '0) ? c_cnt_one : bus.sample_cyc_i;
   assign w_idx_dn = r_idx - c_idx_one;

   // Decide the bit under test and form the next trial code with the next bit set
   always_comb begin
      w_kept = r_dac;
      if (!bus.cmp_i) begin
         w_kept[r_idx] = 1'b0;
      end
      w_trial = w_kept;
      w_trial[w_idx_dn] = 1'b1;
   end

   // Conversion sequencer with all outputs registered
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_dac      <= '0;
         r_result   <= '0;
         r_sample_n <= 1'b1;
         r_busy     <= 1'b0;
         r_eoc      <= 1'b0;
      end else if (!bus.en_i) begin
         // Abort: back to idle without an end-of-conversion, keep last result
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_dac      <= '0;
         r_sample_n <= 1'b1;
         r_busy     <= 1'b0;
         r_eoc      <= 1'b0;
      end else begin
         r_eoc <= 1'b0;
         case (r_state)
            IDLE: begin
               r_sample_n <= 1'b1;
               r_busy     <= 1'b0;
               if (bus.soc_i) begin
                  // Sample length is captured here; later input changes are ignored
                  r_cnt      <= w_s_len;
                  r_sample_n <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= SAMPLE;
               end
            end

            SAMPLE: begin
               if (r_cnt <= c_cnt_one) begin
                  r_cnt      <= '0;
                  r_sample_n <= 1'b1;
                  r_dac      <= c_msb;
                  r_idx      <= c_idx_top;
                  r_state    <= SET;
               end else begin
                  r_cnt <= r_cnt - c_cnt_one;
               end
            end

            // DAC settle cycle before the comparator is trusted
            SET: begin
               r_state <= CHK;
            end

            CHK: begin
               if (r_idx != '0) begin
                  r_dac   <= w_trial;
                  r_idx   <= w_idx_dn;
                  r_state <= SET;
               end else begin
                  r_dac    <= w_kept;
                  r_result <= w_kept;
                  r_state  <= DONE;
               end
            end

            // The pulse becomes visible the cycle after DONE, as the FSM re-enters IDLE
            DONE: begin
               r_eoc   <= 1'b1;
               r_busy  <= 1'b0;
               r_dac   <= '0;
               r_state <= IDLE;
            end

            default: begin
               r_state    <= IDLE;
               r_sample_n <= 1'b1;
               r_busy     <= 1'b0;
               r_dac      <= '0;
            end
         endcase
      end
   end

   assign bus.sample_n_o = r_sample_n;
   assign bus.dac_o      = r_dac;
   assign bus.busy_o     = r_busy;
   assign bus.eoc_o      = r_eoc;
   assign bus.result_o   = r_result;

endmodule : sar_ctrl
`default_nettype wire
